// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and request-legality helpers for the load/store data memory.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int WAIT_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   // Stores only have signed encodings; unsigned variants are loads only.
   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      logic l_st;
      l_st = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      if (we) return l_st;
      return l_st || (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

   // Halves need an even address, words a 4-byte aligned one; bytes never misalign.
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
      case (f3[1:0])
         2'b01:   return addr_lo[0];
         2'b10:   return (addr_lo != 2'b00);
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_data_mem_if.sv
// Request/response bus between the core's load/store stage and the data memory.
interface lsu_data_mem_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane select plus sign/zero extension for loads.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rword,
   output logic [3:0]  o_be,
   output logic [31:0] o_wlanes,
   output logic [31:0] o_rdata
);

   logic [31:0] w_shift;

   // Loads only reach here aligned, so shifting the selected lane down to bit 0 is enough.
   assign w_shift = i_rword >> {i_addr_lo, 3'b000};

   // Store data is replicated to every lane; the byte enables pick which lanes land.
   always_comb begin
      o_be     = 4'b0000;
      o_wlanes = i_wdata;
      case (i_funct3[1:0])
         2'b00: begin
            o_be     = 4'b0001 << i_addr_lo;
            o_wlanes = {4{i_wdata[7:0]}};
         end
         2'b01: begin
            o_be     = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_wlanes = {2{i_wdata[15:0]}};
         end
         2'b10: begin
            o_be     = 4'b1111;
         end
         default: ;
      endcase
   end

   // Extend the selected lane according to the load type.
   always_comb begin
      o_rdata = '0;
      case (i_funct3)
         F3_B:    o_rdata = {{24{w_shift[7]}}, w_shift[7:0]};
         F3_H:    o_rdata = {{16{w_shift[15]}}, w_shift[15:0]};
         F3_W:    o_rdata = i_rword;
         F3_BU:   o_rdata = {24'h0, w_shift[7:0]};
         F3_HU:   o_rdata = {16'h0, w_shift[15:0]};
         default: o_rdata = '0;
      endcase
   end

endmodule

// File: rtl/lsu_data_mem.sv
// Multi-cycle byte-addressed data memory with RV32I load/store handling.
//
//  state  | meaning
//  IDLE   | req_ready high; request checked and captured on handshake
//  ACCESS | wait counter runs down, then memory read/write happens on the edge leaving
//  RESP   | rsp_valid high for one cycle; no back-pressure
module lsu_data_mem
   import lsu_pkg::*;
#(
   parameter int DEPTH_WORDS  = 64,
   parameter int WAIT_STATES  = 0,
   parameter int CLEAR_ON_RST = 1
) (
   input  logic           clk,
   input  logic           rst,
   lsu_data_mem_if.slave  bus
);

   localparam int          IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int          AW      = IDX_W + 2;
   localparam logic [29:0] DEPTH_L = 30'(DEPTH_WORDS);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [WAIT_W-1:0]   r_cnt;
   logic [WAIT_W-1:0]   w_cnt_nxt;
   logic                r_we;
   logic [2:0]          r_funct3;
   logic [AW-1:0]       r_addr;
   logic [31:0]         r_wdata;
   logic [31:0]         r_rdata;
   logic                r_err;
   logic [31:0]         mem [DEPTH_WORDS];

   logic                w_req_err;
   logic                w_accept;
   logic                w_do_access;
   logic                w_do_write;
   logic [IDX_W-1:0]    w_idx;
   logic [31:0]         w_rword;
   logic [3:0]          w_be;
   logic [31:0]         w_wlanes;
   logic [31:0]         w_rdata_ext;

   assign w_req_err = !f3_legal(bus.req_we, bus.req_funct3)
                   || misaligned(bus.req_funct3, bus.req_addr[1:0])
                   || (bus.req_addr[31:2] >= DEPTH_L);

   assign w_idx      = r_addr[AW-1:2];
   assign w_rword    = mem[w_idx];
   assign w_do_write = w_do_access && r_we;

   assign bus.req_ready = (r_state == IDLE);
   assign bus.rsp_valid = (r_state == RESP);
   assign bus.rsp_rdata = r_rdata;
   assign bus.rsp_err   = r_err;

   lsu_align u_align (
      .i_funct3  (r_funct3),
      .i_addr_lo (r_addr[1:0]),
      .i_wdata   (r_wdata),
      .i_rword   (w_rword),
      .o_be      (w_be),
      .o_wlanes  (w_wlanes),
      .o_rdata   (w_rdata_ext)
   );

   // Next-state, wait-counter and strobe decode; errored requests skip ACCESS entirely.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      w_do_access = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.req_valid) begin
               w_accept = 1'b1;
               if (w_req_err) begin
                  w_state_nxt = RESP;
               end else begin
                  w_state_nxt = ACCESS;
                  w_cnt_nxt   = WAIT_W'(WAIT_STATES);
               end
            end
         end
         ACCESS: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else begin
               w_do_access = 1'b1;
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State and wait counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Capture the request on handshake; only the in-range address bits are kept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_we     <= 1'b0;
         r_funct3 <= '0;
         r_addr   <= '0;
         r_wdata  <= '0;
      end else if (w_accept) begin
         r_we     <= bus.req_we;
         r_funct3 <= bus.req_funct3;
         r_addr   <= bus.req_addr[AW-1:0];
         r_wdata  <= bus.req_wdata;
      end
   end

   // Response data/error are only updated when a new response is formed, otherwise held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else if (w_accept && w_req_err) begin
         r_rdata <= '0;
         r_err   <= 1'b1;
      end else if (w_do_access) begin
         r_rdata <= r_we ? 32'h0 : w_rdata_ext;
         r_err   <= 1'b0;
      end
   end

   // Storage: clearing is done on clock edges while rst is held, which keeps the array free
   // of an asynchronous reset. Writes are blocked whenever rst is high.
   if (CLEAR_ON_RST != 0) begin : g_clr
      // Clear on reset, otherwise byte-enabled write.
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
         end else if (w_do_write) begin
            for (int b = 0; b < 4; b++)
               if (w_be[b]) mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
         end
      end
   end else begin : g_keep
      // Contents survive reset; byte-enabled write only.
      always_ff @(posedge clk) begin
         if (!rst && w_do_write) begin
            for (int b = 0; b < 4; b++)
               if (w_be[b]) mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
         end
      end
   end

endmodule
